// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the VGA timing generator.
//   - CNT_W      : raster counter width
//   - COLOR_W    : per-channel colour width
//   - DEF_*      : 640x480@60 default timing
//   - OFF_COLOR  : colour driven while blanked
//   - h_total/v_total : total line/frame length from the porch/sync widths
package vga_timing_pkg;

   localparam int CNT_W     = 11;
   localparam int COLOR_W   = 8;
   localparam int MAX_TOTAL = 1 << CNT_W;

   localparam int DEF_H_VISIBLE = 640;
   localparam int DEF_H_FRONT   = 16;
   localparam int DEF_H_SYNC    = 96;
   localparam int DEF_H_BACK    = 48;
   localparam int DEF_V_VISIBLE = 480;
   localparam int DEF_V_FRONT   = 10;
   localparam int DEF_V_SYNC    = 2;
   localparam int DEF_V_BACK    = 33;

   localparam logic [COLOR_W-1:0] OFF_COLOR = '0;

   function automatic int h_total(input int visible, input int front,
                                  input int sync, input int back);
      return visible + front + sync + back;
   endfunction

   function automatic int v_total(input int visible, input int front,
                                  input int sync, input int back);
      return visible + front + sync + back;
   endfunction

endpackage

// File: rtl/vga_timing_generator_if.sv
// Raster / colour / DAC bundle of the VGA timing generator.
//   master : the timing generator (drives raster + DAC pins, takes en and colour)
//   slave  : the consumer side (image generators, DAC, testbench)
interface vga_timing_generator_if;
   import vga_timing_pkg::*;

   logic                en;
   logic [CNT_W-1:0]    HCNT;
   logic [CNT_W-1:0]    VCNT;
   logic                IAA;
   logic                HS;
   logic                VS;
   logic                FRAME_START;
   logic [COLOR_W-1:0]  R_IN;
   logic [COLOR_W-1:0]  G_IN;
   logic [COLOR_W-1:0]  B_IN;
   logic [COLOR_W-1:0]  VGA_R;
   logic [COLOR_W-1:0]  VGA_G;
   logic [COLOR_W-1:0]  VGA_B;
   logic                VGA_HS;
   logic                VGA_VS;
   logic                VGA_BLANK_N;
   logic                VGA_SYNC_N;

   modport master (
      input  en, R_IN, G_IN, B_IN,
      output HCNT, VCNT, IAA, HS, VS, FRAME_START,
             VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N
   );

   modport slave (
      output en, R_IN, G_IN, B_IN,
      input  HCNT, VCNT, IAA, HS, VS, FRAME_START,
             VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N
   );

endinterface

// File: rtl/vga_sync_delay.sv
// Shift register of configurable width and depth with clock enable and
// synchronous clear. DEPTH=0 degenerates to a wire.
//   clk : clock          en  : shift when 1, hold when 0
//   clr : sync clear to CLR_VAL (priority over en)
//   d   : input word     q   : word delayed by DEPTH enabled cycles
module vga_sync_delay #(
   parameter int               WIDTH   = 3,
   parameter int               DEPTH   = 1,
   parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
   input  logic             clk,
   input  logic             en,
   input  logic             clr,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   generate
      if (DEPTH == 0) begin : g_pass
         logic unused_ctrl;
         assign unused_ctrl = ^{clk, en, clr};
         assign q = d;
      end else begin : g_shift
         logic [WIDTH-1:0] stage [DEPTH];

         always_ff @(posedge clk) begin
            if (clr) begin
               for (int k = 0; k < DEPTH; k++) stage[k] <= CLR_VAL;
            end else if (en) begin
               stage[0] <= d;
               for (int k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
            end
         end

         assign q = stage[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/vga_timing_generator.sv
// Pixel-clock VGA timing master.
// Generates the HCNT/VCNT/IAA/HS/VS/FRAME_START raster for the image
// generators, takes their colour back PIPE_DELAY cycles later, and re-aligns
// it with an equally delayed copy of blank/sync before driving the DAC.
//   VGA_CLK : pixel clock            rst : synchronous reset, active-high
//   vga     : master side of vga_timing_generator_if
//             (en, R/G/B_IN in; raster, VGA_R/G/B, VGA_HS/VS, BLANK_N, SYNC_N out)
module vga_timing_generator
   import vga_timing_pkg::*;
#(
   parameter int   H_VISIBLE  = DEF_H_VISIBLE,
   parameter int   H_FRONT    = DEF_H_FRONT,
   parameter int   H_SYNC     = DEF_H_SYNC,
   parameter int   H_BACK     = DEF_H_BACK,
   parameter int   V_VISIBLE  = DEF_V_VISIBLE,
   parameter int   V_FRONT    = DEF_V_FRONT,
   parameter int   V_SYNC     = DEF_V_SYNC,
   parameter int   V_BACK     = DEF_V_BACK,
   parameter logic H_SYNC_POL = 1'b0,
   parameter logic V_SYNC_POL = 1'b0,
   parameter int   PIPE_DELAY = 1
) (
   input logic                    VGA_CLK,
   input logic                    rst,
   vga_timing_generator_if.master vga
);

   localparam int H_TOTAL = h_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
   localparam int V_TOTAL = v_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

   generate
      if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
         $error("vga_timing_generator: H_TOTAL/V_TOTAL exceed counter range");
      end
      if (PIPE_DELAY < 0 || PIPE_DELAY > 7) begin : g_bad_delay
         $error("vga_timing_generator: PIPE_DELAY must be 0..7");
      end
   endgenerate

   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VISIBLE);
   localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_VISIBLE);
   localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_VISIBLE + H_FRONT);
   localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_VISIBLE + V_FRONT);
   localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);
   // {IAA, HS, VS} as seen during blank with inactive syncs
   localparam logic [2:0]       SYNC_IDLE = {1'b0, ~H_SYNC_POL, ~V_SYNC_POL};

   // p0: h/v hold the pixel that the next enabled edge will present
   logic [CNT_W-1:0] h_p0, v_p0;
   logic [CNT_W-1:0] h_nxt, v_nxt;
   logic             iaa_nxt, hs_nxt, vs_nxt, fs_nxt;

   // p1: raster outputs
   logic [CNT_W-1:0] hcnt_p1, vcnt_p1;
   logic             iaa_p1, hs_p1, vs_p1, fs_p1;

   // p2: delay-line tail merged with colour
   logic [2:0]         sync_tail;
   logic [COLOR_W-1:0] r_p2, g_p2, b_p2;
   logic               blank_n_p2, hs_p2, vs_p2;

   always_comb begin
      h_nxt   = h_p0 + CNT_W'(1);
      v_nxt   = v_p0;
      iaa_nxt = (h_p0 < H_VIS) && (v_p0 < V_VIS);
      hs_nxt  = ~H_SYNC_POL;
      vs_nxt  = ~V_SYNC_POL;
      fs_nxt  = (h_p0 == '0) && (v_p0 == '0);

      if (h_p0 == H_LAST) begin
         h_nxt = '0;
         v_nxt = (v_p0 == V_LAST) ? '0 : v_p0 + CNT_W'(1);
      end
      if (h_p0 >= HS_FIRST && h_p0 <= HS_LAST) hs_nxt = H_SYNC_POL;
      // v only moves on a line wrap, so VS can only toggle alongside HCNT=0
      if (v_p0 >= VS_FIRST && v_p0 <= VS_LAST) vs_nxt = V_SYNC_POL;
   end

   // ---- p0 -> p1: counter advance and raster decode ----
   always_ff @(posedge VGA_CLK) begin
      if (rst) begin
         h_p0    <= '0;
         v_p0    <= '0;
         hcnt_p1 <= '0;
         vcnt_p1 <= '0;
         iaa_p1  <= 1'b0;
         hs_p1   <= ~H_SYNC_POL;
         vs_p1   <= ~V_SYNC_POL;
         fs_p1   <= 1'b0;
      end else if (vga.en) begin
         h_p0    <= h_nxt;
         v_p0    <= v_nxt;
         hcnt_p1 <= h_p0;
         vcnt_p1 <= v_p0;
         iaa_p1  <= iaa_nxt;
         hs_p1   <= hs_nxt;
         vs_p1   <= vs_nxt;
         fs_p1   <= fs_nxt;
      end
   end

   assign vga.HCNT        = hcnt_p1;
   assign vga.VCNT        = vcnt_p1;
   assign vga.IAA         = iaa_p1;
   assign vga.HS          = hs_p1;
   assign vga.VS          = vs_p1;
   assign vga.FRAME_START = fs_p1;

   // ---- p1 -> tail: match the image generators' latency ----
   vga_sync_delay #(
      .WIDTH   (3),
      .DEPTH   (PIPE_DELAY),
      .CLR_VAL (SYNC_IDLE)
   ) u_sync_delay (
      .clk (VGA_CLK),
      .en  (vga.en),
      .clr (rst),
      .d   ({iaa_p1, hs_p1, vs_p1}),
      .q   (sync_tail)
   );

   // ---- tail -> p2: DAC output register, colour gated by delayed IAA ----
   always_ff @(posedge VGA_CLK) begin
      if (rst) begin
         r_p2       <= OFF_COLOR;
         g_p2       <= OFF_COLOR;
         b_p2       <= OFF_COLOR;
         blank_n_p2 <= 1'b0;
         hs_p2      <= ~H_SYNC_POL;
         vs_p2      <= ~V_SYNC_POL;
      end else if (vga.en) begin
         r_p2       <= sync_tail[2] ? vga.R_IN : OFF_COLOR;
         g_p2       <= sync_tail[2] ? vga.G_IN : OFF_COLOR;
         b_p2       <= sync_tail[2] ? vga.B_IN : OFF_COLOR;
         blank_n_p2 <= sync_tail[2];
         hs_p2      <= sync_tail[1];
         vs_p2      <= sync_tail[0];
      end
   end

   assign vga.VGA_R       = r_p2;
   assign vga.VGA_G       = g_p2;
   assign vga.VGA_B       = b_p2;
   assign vga.VGA_BLANK_N = blank_n_p2;
   assign vga.VGA_HS      = hs_p2;
   assign vga.VGA_VS      = vs_p2;
   // no sync-on-green
   assign vga.VGA_SYNC_N  = 1'b0;

endmodule

// File: tb/tb_vga_timing_generator.sv
`timescale 1ns/1ps
// Bench for vga_timing_generator: a 640x480 instance (PIPE_DELAY=1, low
// syncs) and a tiny 32x19 instance (PIPE_DELAY=3, high syncs) share clock,
// reset and enable. Each pixel presented on an enabled edge is logged in a
// history; expected raster comes from the newest entry, expected DAC pins
// from the entry PIPE_DELAY+1 enabled edges old. Colour inputs play the
// image generator by looking up the entry PIPE_DELAY edges old.
module tb_vga_timing_generator;

   localparam int SM_HV = 20, SM_HF = 3, SM_HS = 5, SM_HB = 4;
   localparam int SM_VV = 12, SM_VF = 2, SM_VS = 2, SM_VB = 3;

   typedef struct packed {
      logic [10:0] hcnt;
      logic [10:0] vcnt;
      logic        iaa, hs, vs, fs;
      logic [7:0]  r, g, b;
      logic        vhs, vvs, blank_n, sync_n;
   } obs_t;

   typedef struct {
      bit         blank;
      int         h;
      int         v;
      logic [7:0] b;
   } entry_t;

   logic clk;
   logic rst;
   logic en;

   vga_timing_generator_if if0 ();
   vga_timing_generator_if if1 ();

   vga_timing_generator u_std (
      .VGA_CLK (clk),
      .rst     (rst),
      .vga     (if0)
   );

   vga_timing_generator #(
      .H_VISIBLE (SM_HV), .H_FRONT (SM_HF), .H_SYNC (SM_HS), .H_BACK (SM_HB),
      .V_VISIBLE (SM_VV), .V_FRONT (SM_VF), .V_SYNC (SM_VS), .V_BACK (SM_VB),
      .H_SYNC_POL (1'b1), .V_SYNC_POL (1'b1), .PIPE_DELAY (3)
   ) u_sm (
      .VGA_CLK (clk),
      .rst     (rst),
      .vga     (if1)
   );

   int hv [2] = '{640, SM_HV};
   int hf [2] = '{16,  SM_HF};
   int hsy[2] = '{96,  SM_HS};
   int ht [2] = '{800, SM_HV + SM_HF + SM_HS + SM_HB};
   int vv [2] = '{480, SM_VV};
   int vf [2] = '{10,  SM_VF};
   int vsy[2] = '{2,   SM_VS};
   int vt [2] = '{525, SM_VV + SM_VF + SM_VS + SM_VB};
   int pd [2] = '{1, 3};
   bit hpol[2] = '{1'b0, 1'b1};
   bit vpol[2] = '{1'b0, 1'b1};

   entry_t hist [2][9];
   int     nh [2];
   int     nv [2];
   int     cyc;
   int     n_checks;
   int     n_errs;

   obs_t obs [2];
   assign obs[0] = {if0.HCNT, if0.VCNT, if0.IAA, if0.HS, if0.VS, if0.FRAME_START,
                    if0.VGA_R, if0.VGA_G, if0.VGA_B, if0.VGA_HS, if0.VGA_VS,
                    if0.VGA_BLANK_N, if0.VGA_SYNC_N};
   assign obs[1] = {if1.HCNT, if1.VCNT, if1.IAA, if1.HS, if1.VS, if1.FRAME_START,
                    if1.VGA_R, if1.VGA_G, if1.VGA_B, if1.VGA_HS, if1.VGA_VS,
                    if1.VGA_BLANK_N, if1.VGA_SYNC_N};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached at cyc=%0d", cyc);
      $fatal(1);
   end

   // ---------------- reference model ----------------
   function automatic bit in_hsync(int i, entry_t e);
      return !e.blank && e.h >= hv[i] + hf[i] && e.h < hv[i] + hf[i] + hsy[i];
   endfunction

   function automatic bit in_vsync(int i, entry_t e);
      return !e.blank && e.v >= vv[i] + vf[i] && e.v < vv[i] + vf[i] + vsy[i];
   endfunction

   function automatic bit visible(int i, entry_t e);
      return !e.blank && e.h < hv[i] && e.v < vv[i];
   endfunction

   function automatic obs_t exp_obs(int i);
      obs_t   o;
      entry_t c;
      entry_t d;
      bit     act;
      c = hist[i][0];
      d = hist[i][pd[i] + 1];
      act       = visible(i, d);
      o.hcnt    = c.blank ? 11'd0 : 11'(c.h);
      o.vcnt    = c.blank ? 11'd0 : 11'(c.v);
      o.iaa     = visible(i, c);
      o.hs      = in_hsync(i, c) ? hpol[i] : !hpol[i];
      o.vs      = in_vsync(i, c) ? vpol[i] : !vpol[i];
      o.fs      = !c.blank && c.h == 0 && c.v == 0;
      o.r       = act ? 8'(d.h) : 8'h00;
      o.g       = act ? 8'hFF : 8'h00;
      o.b       = act ? d.b : 8'h00;
      o.vhs     = in_hsync(i, d) ? hpol[i] : !hpol[i];
      o.vvs     = in_vsync(i, d) ? vpol[i] : !vpol[i];
      o.blank_n = act;
      o.sync_n  = 1'b0;
      return o;
   endfunction

   task automatic clear_model();
      for (int i = 0; i < 2; i++) begin
         for (int k = 0; k < 9; k++) begin
            hist[i][k].blank = 1'b1;
            hist[i][k].h     = 0;
            hist[i][k].v     = 0;
            hist[i][k].b     = 8'h00;
         end
         nh[i] = 0;
         nv[i] = 0;
      end
   endtask

   // image generator: colour for the pixel presented pd edges ago
   task automatic drive_inputs();
      entry_t     e;
      logic [7:0] r, b;
      for (int i = 0; i < 2; i++) begin
         e = hist[i][pd[i]];
         r = e.blank ? 8'($urandom) : 8'(e.h);
         b = e.blank ? 8'($urandom) : e.b;
         if (i == 0) begin
            if0.R_IN = r; if0.G_IN = 8'hFF; if0.B_IN = b;
         end else begin
            if1.R_IN = r; if1.G_IN = 8'hFF; if1.B_IN = b;
         end
      end
   endtask

   task automatic set_ctrl(input logic r, input logic e);
      rst    = r;
      en     = e;
      if0.en = e;
      if1.en = e;
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      if (rst) begin
         clear_model();
      end else if (en) begin
         for (int i = 0; i < 2; i++) begin
            for (int k = 8; k > 0; k--) hist[i][k] = hist[i][k-1];
            hist[i][0].blank = 1'b0;
            hist[i][0].h     = nh[i];
            hist[i][0].v     = nv[i];
            hist[i][0].b     = 8'($urandom);
            if (nh[i] == ht[i] - 1) begin
               nh[i] = 0;
               nv[i] = (nv[i] == vt[i] - 1) ? 0 : nv[i] + 1;
            end else begin
               nh[i] = nh[i] + 1;
            end
         end
      end
      #1;
      drive_inputs();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      set_ctrl(1'b1, 1'b1);
      repeat (3) begin
         tick();
         for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (obs[i] !== exp_obs(i)) begin
               n_errs++;
               $display("FAIL reset[%0d] cyc=%0d got=%h exp=%h", i, cyc, obs[i], exp_obs(i));
            end
         end
      end
      n_checks++;
      if (if0.HS !== 1'b1 || if1.HS !== 1'b0 || if0.VGA_VS !== 1'b1 || if1.VGA_VS !== 1'b0) begin
         n_errs++;
         $display("FAIL reset_sync_idle got hs0=%b hs1=%b vvs0=%b vvs1=%b exp 1 0 1 0",
                  if0.HS, if1.HS, if0.VGA_VS, if1.VGA_VS);
      end
   endtask

   task automatic test_first_line();
      int hs_low, hs_fall, vhs_fall, ph, pv;
      logic phs, pvhs;
      set_ctrl(1'b0, 1'b1);
      tick();
      n_checks++;
      if (if0.HCNT !== 11'd0 || if0.VCNT !== 11'd0 || if0.IAA !== 1'b1 || if0.FRAME_START !== 1'b1) begin
         n_errs++;
         $display("FAIL first_edge got h=%0d v=%0d iaa=%b fs=%b exp 0 0 1 1",
                  if0.HCNT, if0.VCNT, if0.IAA, if0.FRAME_START);
      end
      hs_low = 0; hs_fall = -1; vhs_fall = -1;
      phs = if0.HS; pvhs = if0.VGA_HS; ph = int'(if0.HCNT); pv = int'(if0.VCNT);
      if (if0.HS == 1'b0) hs_low++;
      repeat (1700) begin
         tick();
         for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (obs[i] !== exp_obs(i)) begin
               n_errs++;
               $display("FAIL line[%0d] cyc=%0d got=%h exp=%h", i, cyc, obs[i], exp_obs(i));
            end
         end
         if (if0.VCNT == 11'd0 && if0.HS == 1'b0) hs_low++;
         if (phs == 1'b1 && if0.HS == 1'b0 && hs_fall < 0) hs_fall = cyc;
         if (pvhs == 1'b1 && if0.VGA_HS == 1'b0 && vhs_fall < 0) vhs_fall = cyc;
         if (if0.HCNT == 11'd640 && if0.VCNT == 11'd0) begin
            n_checks++;
            if (if0.IAA !== 1'b0) begin
               n_errs++;
               $display("FAIL iaa_at_640 got=%b exp=0", if0.IAA);
            end
         end
         if (ph == 799) begin
            n_checks++;
            if (int'(if0.HCNT) != 0 || int'(if0.VCNT) != pv + 1) begin
               n_errs++;
               $display("FAIL line_wrap got h=%0d v=%0d exp h=0 v=%0d", if0.HCNT, if0.VCNT, pv + 1);
            end
         end
         phs = if0.HS; pvhs = if0.VGA_HS; ph = int'(if0.HCNT); pv = int'(if0.VCNT);
      end
      n_checks++;
      if (hs_low != 96) begin
         n_errs++;
         $display("FAIL hsync_width got=%0d exp=96", hs_low);
      end
      n_checks++;
      if (hs_fall < 0 || vhs_fall - hs_fall != 2) begin
         n_errs++;
         $display("FAIL vga_hs_lag got=%0d exp=2 (hs_fall=%0d)", vhs_fall - hs_fall, hs_fall);
      end
   endtask

   task automatic test_frame();
      int fs_cnt, last_fs, ph, pv;
      logic pvs;
      fs_cnt = 0; last_fs = -1;
      ph = int'(if1.HCNT); pv = int'(if1.VCNT); pvs = if1.VS;
      repeat (3 * 608) begin
         tick();
         for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (obs[i] !== exp_obs(i)) begin
               n_errs++;
               $display("FAIL frame[%0d] cyc=%0d got=%h exp=%h", i, cyc, obs[i], exp_obs(i));
            end
         end
         if (if1.FRAME_START == 1'b1) begin
            fs_cnt++;
            if (last_fs >= 0) begin
               n_checks++;
               if (cyc - last_fs != 608) begin
                  n_errs++;
                  $display("FAIL fs_period got=%0d exp=608", cyc - last_fs);
               end
            end
            last_fs = cyc;
         end
         if (if1.VS !== pvs) begin
            n_checks++;
            if (if1.HCNT !== 11'd0) begin
               n_errs++;
               $display("FAIL vs_edge_at_h got=%0d exp=0", if1.HCNT);
            end
         end
         if (ph == 31 && pv == 18) begin
            n_checks++;
            if (if1.HCNT !== 11'd0 || if1.VCNT !== 11'd0 || if1.FRAME_START !== 1'b1) begin
               n_errs++;
               $display("FAIL frame_wrap got h=%0d v=%0d fs=%b exp 0 0 1",
                        if1.HCNT, if1.VCNT, if1.FRAME_START);
            end
         end
         ph = int'(if1.HCNT); pv = int'(if1.VCNT); pvs = if1.VS;
      end
      n_checks++;
      if (fs_cnt != 3) begin
         n_errs++;
         $display("FAIL fs_count got=%0d exp=3", fs_cnt);
      end
   endtask

   task automatic test_stall();
      obs_t snap [2];
      int   budget;
      budget = 8000;
      while (!(if0.HCNT == 11'd100 && if0.VCNT == 11'd7) && budget > 0) begin
         tick();
         budget--;
         for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (obs[i] !== exp_obs(i)) begin
               n_errs++;
               $display("FAIL stall_run[%0d] cyc=%0d got=%h exp=%h", i, cyc, obs[i], exp_obs(i));
            end
         end
      end
      n_checks++;
      if (budget == 0) begin
         n_errs++;
         $display("FAIL stall_reach got h=%0d v=%0d exp h=100 v=7", if0.HCNT, if0.VCNT);
      end
      snap[0] = obs[0];
      snap[1] = obs[1];
      set_ctrl(1'b0, 1'b0);
      repeat (5) begin
         tick();
         for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (obs[i] !== snap[i] || obs[i] !== exp_obs(i)) begin
               n_errs++;
               $display("FAIL stall_hold[%0d] cyc=%0d got=%h exp=%h", i, cyc, obs[i], snap[i]);
            end
         end
      end
      set_ctrl(1'b0, 1'b1);
      tick();
      n_checks++;
      if (if0.HCNT !== 11'd101 || if0.VCNT !== 11'd7) begin
         n_errs++;
         $display("FAIL stall_resume got h=%0d v=%0d exp h=101 v=7", if0.HCNT, if0.VCNT);
      end
   endtask

   task automatic test_mid_reset();
      int budget;
      budget = 3000;
      while (!(if0.HCNT == 11'd300 && if0.VCNT == 11'd8) && budget > 0) begin
         tick();
         budget--;
         for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (obs[i] !== exp_obs(i)) begin
               n_errs++;
               $display("FAIL mid_run[%0d] cyc=%0d got=%h exp=%h", i, cyc, obs[i], exp_obs(i));
            end
         end
      end
      n_checks++;
      if (budget == 0) begin
         n_errs++;
         $display("FAIL mid_reach got h=%0d v=%0d exp h=300 v=8", if0.HCNT, if0.VCNT);
      end
      set_ctrl(1'b1, 1'b1);
      tick();
      n_checks++;
      if (if0.HCNT !== 11'd0 || if0.VCNT !== 11'd0 || if0.VGA_R !== 8'h00 ||
          if0.VGA_BLANK_N !== 1'b0 || if0.FRAME_START !== 1'b0 || obs[1] !== exp_obs(1)) begin
         n_errs++;
         $display("FAIL mid_reset got h=%0d v=%0d r=%h bn=%b fs=%b exp 0 0 00 0 0",
                  if0.HCNT, if0.VCNT, if0.VGA_R, if0.VGA_BLANK_N, if0.FRAME_START);
      end
      set_ctrl(1'b0, 1'b1);
      tick();
      n_checks++;
      if (if0.HCNT !== 11'd0 || if0.VCNT !== 11'd0 || if0.FRAME_START !== 1'b1 || if0.IAA !== 1'b1) begin
         n_errs++;
         $display("FAIL mid_restart got h=%0d v=%0d fs=%b iaa=%b exp 0 0 1 1",
                  if0.HCNT, if0.VCNT, if0.FRAME_START, if0.IAA);
      end
   endtask

   task automatic test_random();
      repeat (4000) begin
         set_ctrl(($urandom_range(0, 599) == 0), ($urandom_range(0, 3) != 0));
         tick();
         for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (obs[i] !== exp_obs(i)) begin
               n_errs++;
               $display("FAIL random[%0d] cyc=%0d got=%h exp=%h", i, cyc, obs[i], exp_obs(i));
            end
         end
      end
   endtask

   initial begin
      cyc      = 0;
      n_checks = 0;
      n_errs   = 0;
      clear_model();
      set_ctrl(1'b1, 1'b0);
      if0.R_IN = 8'h00; if0.G_IN = 8'h00; if0.B_IN = 8'h00;
      if1.R_IN = 8'h00; if1.G_IN = 8'h00; if1.B_IN = 8'h00;
      test_reset();
      test_first_line();
      test_frame();
      test_stall();
      test_mid_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
